// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: round-robin arbitrated LFSR word generator.
// Two requesters share one 8-bit LFSR; each grant advances it STEPS times
// and delivers the resulting word to the granted requester.
// Optional build macro LFSR_CTRL_CNT_EN adds a saturating 16-bit word_cnt output.
module lfsr_ctrl #(
    parameter int unsigned STEPS        = 8,
    parameter logic [7:0]  SEED_DEFAULT = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_valid,
    input  logic [7:0]  seed_data,
    output logic        seed_ready,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_id,
    output logic        busy
`ifdef LFSR_CTRL_CNT_EN
    ,
    output logic [15:0] word_cnt
`endif
);

    localparam logic [7:0] LAST_STEP = 8'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DELIVER} state_t;

    state_t     state, state_nxt;
    logic [7:0] s, s_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       prio, prio_nxt;
    logic       id, id_nxt;
    logic       sel;
    logic       word_done;

    // State register; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            s     <= SEED_DEFAULT;
            cnt   <= 8'd0;
            prio  <= 1'b0;
            id    <= 1'b0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            cnt   <= cnt_nxt;
            prio  <= prio_nxt;
            id    <= id_nxt;
        end
    end

    // Next-state, arbitration and output decode; all outputs forced low in reset.
    always_comb begin
        state_nxt  = state;
        s_nxt      = s;
        cnt_nxt    = cnt;
        prio_nxt   = prio;
        id_nxt     = id;
        sel        = 1'b0;
        word_done  = 1'b0;
        gnt        = 2'b00;
        seed_ready = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_id     = 1'b0;
        busy       = 1'b0;

        case (state)
            IDLE: begin
                seed_ready = 1'b1;
                if (seed_valid) begin
                    s_nxt = (seed_data == 8'h00) ? SEED_DEFAULT : seed_data;
                end else if (req != 2'b00) begin
                    sel       = (req == 2'b11) ? prio : req[1];
                    gnt       = sel ? 2'b10 : 2'b01;
                    id_nxt    = sel;
                    prio_nxt  = ~sel;
                    cnt_nxt   = 8'd0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                s_nxt = (s == 8'h00) ? SEED_DEFAULT
                                     : {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
                if (cnt == LAST_STEP) begin
                    state_nxt = DELIVER;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DELIVER: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = s;
                out_id    = id;
                if (out_ready) begin
                    word_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!rst) begin
            gnt        = 2'b00;
            seed_ready = 1'b0;
            out_valid  = 1'b0;
            out_data   = 8'h00;
            out_id     = 1'b0;
            busy       = 1'b0;
            word_done  = 1'b0;
        end
    end

`ifdef LFSR_CTRL_CNT_EN
    // Saturating count of delivered words.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_cnt <= 16'h0000;
        end else if (word_done && (word_cnt != 16'hFFFF)) begin
            word_cnt <= word_cnt + 16'h0001;
        end
    end
`endif

endmodule
